// File: rtl/l1_cache_core_pkg.sv
// l1_cache_core_pkg
// Shared constants and types for the L1 cache slice.
// Default geometry: 11-bit byte address, 8-bit bytes, 256-byte cache, 16-byte lines, 2 ways.
// Also holds the derived set count and field widths, the line type and the FSM state encoding.
package l1_cache_core_pkg;

    localparam int ADDR_W      = 11;
    localparam int DATA_W      = 8;
    localparam int CACHE_BYTES = 256;
    localparam int BLOCK_BYTES = 16;
    localparam int WAYS        = 2;

    localparam int SETS     = CACHE_BYTES / BLOCK_BYTES / WAYS;
    localparam int OFFSET_W = $clog2(BLOCK_BYTES);
    localparam int INDEX_W  = $clog2(SETS);
    localparam int TAG_W    = ADDR_W - OFFSET_W - INDEX_W;
    localparam int WAY_W    = $clog2(WAYS);
    localparam int LINE_W   = BLOCK_BYTES * DATA_W;

    typedef logic [LINE_W-1:0] line_t;

    // FSM state encoding.
    typedef logic [1:0] state_t;
    localparam state_t IDLE      = 2'd0;
    localparam state_t WRITEBACK = 2'd1;
    localparam state_t FILL      = 2'd2;
    localparam state_t RESPOND   = 2'd3;

endpackage

// File: rtl/l1_cache_core_if.sv
// l1_cache_core_if
// Bundles the CPU-side request/response and the L2-side line transfer signals.
//   slave  : the cache view. CPU request and L2 response are inputs; CPU response and L2 request are outputs.
//   master : the environment view, which is the mirror image of the slave view.
interface l1_cache_core_if;
    import l1_cache_core_pkg::*;

    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_data_in;
    logic              cpu_read;
    logic              cpu_write;
    logic [DATA_W-1:0] cpu_data_out;
    logic              cpu_ready;
    logic              l1_hit;

    logic [ADDR_W-1:0] l2_cache_addr;
    line_t             l2_cache_data_out;
    line_t             l2_cache_data_in;
    logic              l2_cache_read;
    logic              l2_cache_write;
    logic              l2_cache_ready;
    logic              l2_cache_hit;

    modport slave (
        input  cpu_addr, cpu_data_in, cpu_read, cpu_write,
        output cpu_data_out, cpu_ready, l1_hit,
        output l2_cache_addr, l2_cache_data_out, l2_cache_read, l2_cache_write,
        input  l2_cache_data_in, l2_cache_ready, l2_cache_hit
    );

    modport master (
        output cpu_addr, cpu_data_in, cpu_read, cpu_write,
        input  cpu_data_out, cpu_ready, l1_hit,
        input  l2_cache_addr, l2_cache_data_out, l2_cache_read, l2_cache_write,
        output l2_cache_data_in, l2_cache_ready, l2_cache_hit
    );

endinterface

// File: rtl/l1_tag_match.sv
// l1_tag_match
// Combinational tag compare for the ways of one set.
//   set_valid/set_tags : valid bits and tags of the addressed set
//   lru                : way to evict when every way is valid
//   req_tag            : tag of the incoming request
//   hit/hit_way        : request hits, and in which way
//   victim_way         : lowest-numbered invalid way, otherwise the LRU way
module l1_tag_match
    import l1_cache_core_pkg::*;
#(
    parameter int NUM_WAYS = WAYS,
    parameter int TAG_BITS = TAG_W,
    parameter int WAY_BITS = WAY_W
) (
    input  logic [NUM_WAYS-1:0]               set_valid,
    input  logic [NUM_WAYS-1:0][TAG_BITS-1:0] set_tags,
    input  logic [WAY_BITS-1:0]               lru,
    input  logic [TAG_BITS-1:0]               req_tag,
    output logic                              hit,
    output logic [WAY_BITS-1:0]               hit_way,
    output logic [WAY_BITS-1:0]               victim_way
);

    logic [NUM_WAYS-1:0] match;

    for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_match
        assign match[gi] = set_valid[gi] && (set_tags[gi] == req_tag);
    end

    // Scanning from the top way down means the lowest-numbered way wins.
    always_comb begin
        hit        = |match;
        hit_way    = '0;
        victim_way = lru;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (match[w]) begin
                hit_way = WAY_BITS'(w);
            end
            if (!set_valid[w]) begin
                victim_way = WAY_BITS'(w);
            end
        end
    end

endmodule

// File: rtl/l1_cache_core.sv
// l1_cache_core
// Write-back, write-allocate set-associative L1 cache with 1-bit LRU per set.
//   clk   : rising-edge clock
//   rst_n : asynchronous reset, active HIGH despite its name
//   bus   : slave side of l1_cache_core_if
//           CPU side  : byte requests held by the CPU until the one-cycle cpu_ready pulse
//           L2 side   : whole-line write-back and fill, each held until l2_cache_ready
// valid/dirty/tags/data/lru are plain arrays so the hierarchy can be inspected.
module l1_cache_core
    import l1_cache_core_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int DATA_WIDTH = DATA_W,
    parameter int CACHE_SIZE = CACHE_BYTES,
    parameter int BLOCK_SIZE = BLOCK_BYTES,
    parameter int NUM_WAYS   = WAYS
) (
    input logic           clk,
    input logic           rst_n,
    l1_cache_core_if.slave bus
);

    localparam int NUM_SETS  = CACHE_SIZE / BLOCK_SIZE / NUM_WAYS;
    localparam int OFF_BITS  = $clog2(BLOCK_SIZE);
    localparam int IDX_BITS  = $clog2(NUM_SETS);
    localparam int TAG_BITS  = ADDR_WIDTH - OFF_BITS - IDX_BITS;
    localparam int WAY_BITS  = $clog2(NUM_WAYS);
    localparam int LINE_BITS = BLOCK_SIZE * DATA_WIDTH;

    logic                 valid [NUM_SETS][NUM_WAYS];
    logic                 dirty [NUM_SETS][NUM_WAYS];
    logic [TAG_BITS-1:0]  tags  [NUM_SETS][NUM_WAYS];
    logic [LINE_BITS-1:0] data  [NUM_SETS][NUM_WAYS];
    logic [WAY_BITS-1:0]  lru   [NUM_SETS];

    state_t                state_reg;
    logic [ADDR_WIDTH-1:0] req_addr_reg;
    logic [DATA_WIDTH-1:0] req_data_reg;
    logic                  req_write_reg;
    logic [WAY_BITS-1:0]   victim_reg;

    // The incoming request is decoded straight from the bus while in IDLE. Once the
    // request is accepted, the latched copy drives the miss path.
    logic [OFF_BITS-1:0] cpu_off, req_off;
    logic [IDX_BITS-1:0] cpu_idx, req_idx;
    logic [TAG_BITS-1:0] cpu_tag, req_tag;

    assign cpu_off = bus.cpu_addr[OFF_BITS-1:0];
    assign cpu_idx = bus.cpu_addr[OFF_BITS +: IDX_BITS];
    assign cpu_tag = bus.cpu_addr[ADDR_WIDTH-1 -: TAG_BITS];
    assign req_off = req_addr_reg[OFF_BITS-1:0];
    assign req_idx = req_addr_reg[OFF_BITS +: IDX_BITS];
    assign req_tag = req_addr_reg[ADDR_WIDTH-1 -: TAG_BITS];

    logic [NUM_WAYS-1:0]               set_valid;
    logic [NUM_WAYS-1:0][TAG_BITS-1:0] set_tags;

    for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_set
        assign set_valid[gi] = valid[cpu_idx][gi];
        assign set_tags[gi]  = tags[cpu_idx][gi];
    end

    logic                hit;
    logic [WAY_BITS-1:0] hit_way, victim_way;

    l1_tag_match #(
        .NUM_WAYS (NUM_WAYS),
        .TAG_BITS (TAG_BITS),
        .WAY_BITS (WAY_BITS)
    ) u_tag_match (
        .set_valid  (set_valid),
        .set_tags   (set_tags),
        .lru        (lru[cpu_idx]),
        .req_tag    (cpu_tag),
        .hit        (hit),
        .hit_way    (hit_way),
        .victim_way (victim_way)
    );

    logic                  accept, hit_write, fill_done, need_wb;
    logic [LINE_BITS-1:0]  hit_line, victim_line, fill_line;
    logic [DATA_WIDTH-1:0] hit_byte, fill_byte;

    assign accept      = (state_reg == IDLE) && (bus.cpu_read || bus.cpu_write);
    assign hit_write   = accept && hit && bus.cpu_write;
    assign fill_done   = (state_reg == FILL) && bus.l2_cache_ready;
    assign hit_line    = data[cpu_idx][hit_way];
    assign victim_line = data[cpu_idx][victim_way];
    assign need_wb     = valid[cpu_idx][victim_way] && dirty[cpu_idx][victim_way];
    assign hit_byte    = hit_line[cpu_off*DATA_WIDTH +: DATA_WIDTH];
    assign fill_byte   = bus.l2_cache_data_in[req_off*DATA_WIDTH +: DATA_WIDTH];

    // A write miss installs the fetched line with the CPU byte already merged in.
    always_comb begin
        fill_line = bus.l2_cache_data_in;
        if (req_write_reg) begin
            fill_line[req_off*DATA_WIDTH +: DATA_WIDTH] = req_data_reg;
        end
    end

    // l2_cache_hit is informational only.
    logic unused_l2_hit;
    assign unused_l2_hit = bus.l2_cache_hit;

    // Tag and data storage carry no reset. Stale contents are harmless because the
    // valid bits are cleared.
    always_ff @(posedge clk) begin
        if (hit_write) begin
            data[cpu_idx][hit_way][cpu_off*DATA_WIDTH +: DATA_WIDTH] <= bus.cpu_data_in;
        end
        if (fill_done) begin
            data[req_idx][victim_reg] <= fill_line;
            tags[req_idx][victim_reg] <= req_tag;
        end
    end

    // Control path. The 1-bit LRU records the way that was not touched, so
    // inverting the accessed way gives the next victim.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_reg             <= IDLE;
            req_addr_reg          <= '0;
            req_data_reg          <= '0;
            req_write_reg         <= 1'b0;
            victim_reg            <= '0;
            bus.cpu_ready         <= 1'b0;
            bus.l1_hit            <= 1'b0;
            bus.cpu_data_out      <= '0;
            bus.l2_cache_read     <= 1'b0;
            bus.l2_cache_write    <= 1'b0;
            bus.l2_cache_addr     <= '0;
            bus.l2_cache_data_out <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                lru[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    valid[s][w] <= 1'b0;
                    dirty[s][w] <= 1'b0;
                end
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        req_addr_reg  <= bus.cpu_addr;
                        req_data_reg  <= bus.cpu_data_in;
                        req_write_reg <= bus.cpu_write;
                        victim_reg    <= victim_way;
                        if (hit) begin
                            bus.cpu_ready    <= 1'b1;
                            bus.l1_hit       <= 1'b1;
                            bus.cpu_data_out <= bus.cpu_write ? bus.cpu_data_in : hit_byte;
                            if (bus.cpu_write) begin
                                dirty[cpu_idx][hit_way] <= 1'b1;
                            end
                            lru[cpu_idx] <= ~hit_way;
                            state_reg    <= RESPOND;
                        end else if (need_wb) begin
                            bus.l2_cache_write    <= 1'b1;
                            bus.l2_cache_addr     <= {tags[cpu_idx][victim_way], cpu_idx, {OFF_BITS{1'b0}}};
                            bus.l2_cache_data_out <= victim_line;
                            state_reg             <= WRITEBACK;
                        end else begin
                            bus.l2_cache_read <= 1'b1;
                            bus.l2_cache_addr <= {cpu_tag, cpu_idx, {OFF_BITS{1'b0}}};
                            state_reg         <= FILL;
                        end
                    end
                end
                WRITEBACK: begin
                    if (bus.l2_cache_ready) begin
                        bus.l2_cache_write <= 1'b0;
                        bus.l2_cache_read  <= 1'b1;
                        bus.l2_cache_addr  <= {req_tag, req_idx, {OFF_BITS{1'b0}}};
                        state_reg          <= FILL;
                    end
                end
                FILL: begin
                    if (bus.l2_cache_ready) begin
                        bus.l2_cache_read           <= 1'b0;
                        valid[req_idx][victim_reg]  <= 1'b1;
                        dirty[req_idx][victim_reg]  <= req_write_reg;
                        lru[req_idx]                <= ~victim_reg;
                        bus.cpu_ready               <= 1'b1;
                        bus.l1_hit                  <= 1'b0;
                        bus.cpu_data_out            <= req_write_reg ? req_data_reg : fill_byte;
                        state_reg                   <= RESPOND;
                    end
                end
                RESPOND: begin
                    bus.cpu_ready <= 1'b0;
                    bus.l1_hit    <= 1'b0;
                    state_reg     <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l1_cache_core.sv
// tb_l1_cache_core
// Directed test of l1_cache_core against a small L2 memory model with a fixed
// two-cycle response latency.
module tb_l1_cache_core;
    import l1_cache_core_pkg::*;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    l1_cache_core_if bus();

    l1_cache_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_init(input int a);
        logic [10:0] x;
        x = a[10:0];
        return x[7:0] ^ {x[10:8], 5'b0};
    endfunction

    // L2 model: byte-addressed memory with a two-cycle response latency.
    logic [7:0]  mem [2048];
    int          fills = 0;
    int          wbs   = 0;
    int          lat   = 0;
    logic [10:0] last_rd_addr = '0;
    logic [10:0] last_wr_addr = '0;
    line_t       last_wr_line = '0;

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = mem_init(i);
        bus.l2_cache_ready   = 1'b0;
        bus.l2_cache_data_in = '0;
        bus.l2_cache_hit     = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                bus.l2_cache_ready = 1'b0;
                lat = 0;
            end else if (bus.l2_cache_ready) begin
                bus.l2_cache_ready = 1'b0;
                lat = 0;
            end else if (bus.l2_cache_read || bus.l2_cache_write) begin
                lat++;
                if (lat >= 2) begin
                    if (bus.l2_cache_write) begin
                        wbs++;
                        last_wr_addr = bus.l2_cache_addr;
                        last_wr_line = bus.l2_cache_data_out;
                        for (int k = 0; k < 16; k++)
                            mem[int'(bus.l2_cache_addr) + k] = bus.l2_cache_data_out[k*8 +: 8];
                    end else begin
                        fills++;
                        last_rd_addr = bus.l2_cache_addr;
                        for (int k = 0; k < 16; k++)
                            bus.l2_cache_data_in[k*8 +: 8] = mem[int'(bus.l2_cache_addr) + k];
                    end
                    bus.l2_cache_ready = 1'b1;
                end
            end
        end
    end

    int both_cnt = 0;
    always @(negedge clk) begin
        if (bus.l2_cache_read && bus.l2_cache_write) both_cnt <= both_cnt + 1;
    end

    // One CPU transaction. Cycles are counted from the accepting edge to the edge
    // that raises cpu_ready. The task returns one edge later, when the cache is back in IDLE.
    task automatic do_access(input logic wr, input logic [10:0] a, input logic [7:0] d,
                             output logic [7:0] q, output logic h, output int cyc);
        logic got;
        @(negedge clk);
        bus.cpu_addr    = a;
        bus.cpu_data_in = d;
        bus.cpu_write   = wr;
        bus.cpu_read    = !wr;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.cpu_ready) got = 1'b1;
        end
        check("ready_seen", got, 1);
        q = bus.cpu_data_out;
        h = bus.l1_hit;
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
        $display("txn %s addr=0x%03h din=0x%02h dout=0x%02h hit=%0d cycles=%0d",
                 wr ? "WR" : "RD", a, d, q, h, cyc);
        @(posedge clk);
    endtask

    initial begin
        logic [7:0] q;
        logic       h;
        int         cyc;
        int         f0;
        int         w0;
        logic       seen;

        rst_n           = 1'b1;
        bus.cpu_addr    = '0;
        bus.cpu_data_in = '0;
        bus.cpu_read    = 1'b0;
        bus.cpu_write   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cpu_ready", bus.cpu_ready, 0);
        check("rst_l1_hit", bus.l1_hit, 0);
        check("rst_l2_read", bus.l2_cache_read, 0);
        check("rst_l2_write", bus.l2_cache_write, 0);
        check("rst_data_out", bus.cpu_data_out, 0);
        check("rst_l2_addr", bus.l2_cache_addr, 0);
        check("rst_l2_line_lo", bus.l2_cache_data_out[31:0], 0);
        @(negedge clk);
        rst_n = 1'b0;

        // Cold miss on address 0x000.
        f0 = fills; w0 = wbs;
        do_access(1'b0, 11'h000, 8'h00, q, h, cyc);
        check("m0_fill_cnt", fills - f0, 1);
        check("m0_fill_addr", last_rd_addr, 11'h000);
        check("m0_wb_cnt", wbs - w0, 0);
        check("m0_data", q, 8'h00);
        check("m0_hit", h, 0);

        // Hit on the same line, at its last byte.
        f0 = fills;
        do_access(1'b0, 11'h00F, 8'h00, q, h, cyc);
        check("h0_latency", cyc, 1);
        check("h0_hit", h, 1);
        check("h0_data", q, 8'h0F);
        check("h0_fill_cnt", fills - f0, 0);

        // Three lines mapping to set 0. The third evicts the clean line 0x000.
        do_access(1'b0, 11'h000, 8'h00, q, h, cyc);
        check("s0_a_hit", h, 1);
        do_access(1'b0, 11'h080, 8'h00, q, h, cyc);
        check("s0_b_hit", h, 0);
        check("s0_b_data", q, 8'h80);
        f0 = fills; w0 = wbs;
        do_access(1'b0, 11'h100, 8'h00, q, h, cyc);
        check("s0_c_hit", h, 0);
        check("s0_c_fill_addr", last_rd_addr, 11'h100);
        check("s0_c_wb_cnt", wbs - w0, 0);
        check("s0_c_data", q, 8'h20);

        // Write miss on the evicted line. The clean victim 0x080 is refilled without a write-back.
        f0 = fills; w0 = wbs;
        do_access(1'b1, 11'h005, 8'hAA, q, h, cyc);
        check("wm_fill_cnt", fills - f0, 1);
        check("wm_wb_cnt", wbs - w0, 0);
        check("wm_hit", h, 0);
        check("wm_data", q, 8'hAA);
        do_access(1'b0, 11'h085, 8'h00, q, h, cyc);
        check("wm_b_data", q, 8'h85);

        // This access evicts the dirty line 0x000.
        f0 = fills; w0 = wbs;
        do_access(1'b0, 11'h105, 8'h00, q, h, cyc);
        check("wb_cnt", wbs - w0, 1);
        check("wb_addr", last_wr_addr, 11'h000);
        check("wb_byte5", last_wr_line[5*8 +: 8], 8'hAA);
        check("wb_byte0", last_wr_line[7:0], 8'h00);
        check("wb_fill_addr", last_rd_addr, 11'h100);
        check("wb_fill_cnt", fills - f0, 1);
        check("wb_data", q, 8'h25);

        // cpu_data_out holds while idle.
        repeat (3) @(posedge clk);
        #1;
        check("hold_data", bus.cpu_data_out, 8'h25);

        // The written-back byte comes back from L2.
        do_access(1'b0, 11'h005, 8'h00, q, h, cyc);
        check("rt_hit", h, 0);
        check("rt_data", q, 8'hAA);

        // Reset between transactions clears the outputs.
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        check("rst2_data_out", bus.cpu_data_out, 0);
        check("rst2_ready", bus.cpu_ready, 0);
        @(negedge clk);
        rst_n = 1'b0;

        // Full sweep of the address space after reset.
        f0 = fills; w0 = wbs;
        for (int a = 0; a < 2048; a++) begin
            do_access(1'b0, 11'(a), 8'h00, q, h, cyc);
            check($sformatf("sweep_%03h", a), q, (a == 5) ? 8'hAA : mem_init(a));
        end
        check("sweep_fills", fills - f0, 128);
        check("sweep_wbs", wbs - w0, 0);

        // Reset in the middle of a fill drops the strobe without a clock edge.
        @(negedge clk);
        bus.cpu_addr = 11'h300;
        bus.cpu_read = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #2;
            if (bus.l2_cache_read) seen = 1'b1;
        end
        check("abort_strobe_seen", seen, 1);
        check("abort_addr", bus.l2_cache_addr, 11'h300);
        #1 rst_n = 1'b1;
        #1;
        check("abort_read_drop", bus.l2_cache_read, 0);
        bus.cpu_read = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;

        f0 = fills;
        do_access(1'b0, 11'h300, 8'h00, q, h, cyc);
        check("refill_hit", h, 0);
        check("refill_cnt", fills - f0, 1);
        check("refill_addr", last_rd_addr, 11'h300);
        check("refill_data", q, 8'h60);

        check("strobe_exclusive", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
